sbox_arbiter: RTL

SBOX_ARBITER -- requirements
Module: sbox_arbiter

---
 rtl/sbox_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/sbox_arbiter.sv
// Round-robin arbiter sharing one pipelined TI S-box between the state path and the key schedule.
// Optional macro SBARB_ZERO_IDLE_EN forces sb_din to zero on cycles without a transfer.
module sbox_arbiter #(
    parameter int unsigned SHARES   = 3,
    parameter int unsigned SBOX_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_req,
    input  logic [8*SHARES-1:0]   st_din,
    output logic                  st_gnt,
    output logic                  st_vld,
    output logic [8*SHARES-1:0]   st_dout,
    input  logic                  ks_req,
    input  logic [8*SHARES-1:0]   ks_din,
    output logic                  ks_gnt,
    output logic                  ks_vld,
    output logic [8*SHARES-1:0]   ks_dout,
    output logic [8*SHARES-1:0]   sb_din,
    input  logic [8*SHARES-1:0]   sb_dout,
    output logic                  busy
);

    typedef enum logic {
        OWN_ST = 1'b0,
        OWN_KS = 1'b1
    } owner_t;

    owner_t                  r_last_win;
    logic [SBOX_LAT:1]       r_tag_vld;
    owner_t                  r_tag_own [1:SBOX_LAT];
    logic                    r_st_vld;
    logic                    r_ks_vld;
    logic [8*SHARES-1:0]     r_st_dout;
    logic [8*SHARES-1:0]     r_ks_dout;

    logic                    w_st_gnt;
    logic                    w_ks_gnt;
    logic                    w_xfer;
    logic                    w_out_vld;
    owner_t                  w_out_own;

    // On a tie the side that did not win the most recent transfer is granted.
    assign w_st_gnt  = ~rst & st_req & (~ks_req | (r_last_win == OWN_KS));
    assign w_ks_gnt  = ~rst & ks_req & (~st_req | (r_last_win == OWN_ST));
    assign w_xfer    = w_st_gnt | w_ks_gnt;
    assign w_out_vld = r_tag_vld[SBOX_LAT];
    assign w_out_own = r_tag_own[SBOX_LAT];

`ifdef SBARB_ZERO_IDLE_EN
    assign sb_din = w_ks_gnt ? ks_din : (w_st_gnt ? st_din : '0);
`else
    assign sb_din = w_ks_gnt ? ks_din : st_din;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_win <= OWN_ST;
            r_tag_vld  <= '0;
            for (int unsigned i = 1; i <= SBOX_LAT; i++) begin
                r_tag_own[i] <= OWN_ST;
            end
            r_st_vld   <= 1'b0;
            r_ks_vld   <= 1'b0;
            r_st_dout  <= '0;
            r_ks_dout  <= '0;
        end else begin
            // Stage k holds the tag of the transfer issued k cycles ago.
            r_tag_vld[1] <= w_xfer;
            r_tag_own[1] <= w_ks_gnt ? OWN_KS : OWN_ST;
            for (int unsigned i = 2; i <= SBOX_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_own[i] <= r_tag_own[i-1];
            end

            if (w_xfer) begin
                r_last_win <= w_ks_gnt ? OWN_KS : OWN_ST;
            end

            r_st_vld <= w_out_vld & (w_out_own == OWN_ST);
            r_ks_vld <= w_out_vld & (w_out_own == OWN_KS);
            if (w_out_vld && (w_out_own == OWN_ST)) begin
                r_st_dout <= sb_dout;
            end
            if (w_out_vld && (w_out_own == OWN_KS)) begin
                r_ks_dout <= sb_dout;
            end
        end
    end

    assign st_gnt  = w_st_gnt;
    assign ks_gnt  = w_ks_gnt;
    assign st_vld  = r_st_vld;
    assign ks_vld  = r_ks_vld;
    assign st_dout = r_st_dout;
    assign ks_dout = r_ks_dout;
    assign busy    = (|r_tag_vld) | r_st_vld | r_ks_vld;

endmodule
